// File: rtl/req_issuer.sv
// req_issuer
// ----------
// Upstream requester for a req/ack edge-detect responder. Command words are
// queued in a small FIFO; each one is presented as a level request (o_req with
// o_req_data) until the responder answers with a one-cycle i_ack pulse. After
// every attempt o_req is held low for GAP cycles so that the responder always
// sees a fresh rising edge. An attempt with no ack is abandoned after TIMEOUT
// high cycles and re-issued up to MAX_RETRY times. After that the word is
// dropped with an o_err pulse.
//
// Command handshake: a word is transferred on a rising clock edge where both
// i_cmd_valid and o_cmd_ready are 1. o_cmd_ready depends only on the FIFO
// occupancy, never on i_cmd_valid.
//
// Ports
//   i_clk, i_rst          clock, asynchronous active-high reset
//   i_cmd_valid/_data     command offer from the source
//   o_cmd_ready           FIFO not full (combinational from the count)
//   o_req, o_req_data     level request and its data (registered)
//   i_ack                 one-cycle acknowledge from the responder
//   o_done, o_done_data   one-cycle pulse with data of an acked transaction
//   o_err                 one-cycle pulse: transaction dropped after last timeout
//   o_busy                FSM not idle (registered)
//   o_pending             FIFO occupancy
//   o_state               current FSM state, for observation
module req_issuer #(
    parameter int DATA_W    = 8,
    parameter int DEPTH     = 4,
    parameter int TIMEOUT   = 15,
    parameter int MAX_RETRY = 3,
    parameter int GAP       = 2
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    input  logic                         i_cmd_valid,
    input  logic [DATA_W-1:0]            i_cmd_data,
    output logic                         o_cmd_ready,
    output logic                         o_req,
    output logic [DATA_W-1:0]            o_req_data,
    input  logic                         i_ack,
    output logic                         o_done,
    output logic [DATA_W-1:0]            o_done_data,
    output logic                         o_err,
    output logic                         o_busy,
    output logic [$clog2(DEPTH+1)-1:0]   o_pending,
    output logic [1:0]                   o_state
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int RW = $clog2(MAX_RETRY + 1) + 1;
    localparam int GW = $clog2(GAP + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_GAP  = 2'd2
    } state_t;

    // FIFO storage
    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [PW-1:0]     r_wr_ptr;
    logic [PW-1:0]     r_rd_ptr;
    logic [CW-1:0]     r_count;

    // FSM and datapath registers
    state_t            r_state;
    logic              r_req;
    logic [DATA_W-1:0] r_cur;
    logic [TW-1:0]     r_to_cnt;
    logic [GW-1:0]     r_gap_cnt;
    logic [RW-1:0]     r_retry;
    logic              r_retry_pend;
    logic              r_done;
    logic [DATA_W-1:0] r_done_data;
    logic              r_err;
    logic              r_busy;

    // Next-state values
    state_t            w_state_nx;
    logic              w_req_nx;
    logic [DATA_W-1:0] w_cur_nx;
    logic [TW-1:0]     w_to_nx;
    logic [GW-1:0]     w_gap_nx;
    logic [RW-1:0]     w_retry_nx;
    logic              w_rpend_nx;
    logic              w_done_nx;
    logic [DATA_W-1:0] w_done_data_nx;
    logic              w_err_nx;

    logic              w_push;
    logic              w_pop;
    logic              w_empty;
    logic [DATA_W-1:0] w_head;

    assign o_cmd_ready = (r_count != CW'(DEPTH));
    assign o_pending   = r_count;
    assign w_push      = i_cmd_valid & o_cmd_ready;
    assign w_empty     = (r_count == '0);
    assign w_head      = r_mem[r_rd_ptr];

    assign o_req       = r_req;
    assign o_req_data  = r_cur;
    assign o_done      = r_done;
    assign o_done_data = r_done_data;
    assign o_err       = r_err;
    assign o_busy      = r_busy;
    assign o_state     = r_state;

    // Storage is not reset; occupancy and pointers define what is valid.
    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_cmd_data;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_comb begin
        w_state_nx     = r_state;
        w_req_nx       = r_req;
        w_cur_nx       = r_cur;
        w_to_nx        = r_to_cnt;
        w_gap_nx       = r_gap_cnt;
        w_retry_nx     = r_retry;
        w_rpend_nx     = r_retry_pend;
        w_done_nx      = 1'b0;
        w_done_data_nx = r_done_data;
        w_err_nx       = 1'b0;
        w_pop          = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (!w_empty) begin
                    w_pop      = 1'b1;
                    w_cur_nx   = w_head;
                    w_retry_nx = '0;
                    w_to_nx    = '0;
                    w_req_nx   = 1'b1;
                    w_state_nx = S_REQ;
                end
            end
            S_REQ: begin
                // An ack on the final timeout cycle still counts as success.
                if (i_ack) begin
                    w_req_nx       = 1'b0;
                    w_done_nx      = 1'b1;
                    w_done_data_nx = r_cur;
                    w_rpend_nx     = 1'b0;
                    w_gap_nx       = '0;
                    w_state_nx     = S_GAP;
                end else if (r_to_cnt == TW'(TIMEOUT - 1)) begin
                    w_req_nx   = 1'b0;
                    w_gap_nx   = '0;
                    w_state_nx = S_GAP;
                    if (r_retry == RW'(MAX_RETRY)) begin
                        w_err_nx   = 1'b1;
                        w_rpend_nx = 1'b0;
                    end else begin
                        w_retry_nx = r_retry + 1'b1;
                        w_rpend_nx = 1'b1;
                    end
                end else begin
                    w_to_nx = r_to_cnt + 1'b1;
                end
            end
            S_GAP: begin
                if (r_gap_cnt == GW'(GAP - 1)) begin
                    if (r_retry_pend) begin
                        // Re-issue the same word; retry count is kept.
                        w_req_nx   = 1'b1;
                        w_to_nx    = '0;
                        w_rpend_nx = 1'b0;
                        w_state_nx = S_REQ;
                    end else if (!w_empty) begin
                        w_pop      = 1'b1;
                        w_cur_nx   = w_head;
                        w_retry_nx = '0;
                        w_to_nx    = '0;
                        w_req_nx   = 1'b1;
                        w_state_nx = S_REQ;
                    end else begin
                        w_state_nx = S_IDLE;
                    end
                end else begin
                    w_gap_nx = r_gap_cnt + 1'b1;
                end
            end
            default: begin
                w_req_nx   = 1'b0;
                w_state_nx = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state      <= S_IDLE;
            r_req        <= 1'b0;
            r_cur        <= '0;
            r_to_cnt     <= '0;
            r_gap_cnt    <= '0;
            r_retry      <= '0;
            r_retry_pend <= 1'b0;
            r_done       <= 1'b0;
            r_done_data  <= '0;
            r_err        <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            r_state      <= w_state_nx;
            r_req        <= w_req_nx;
            r_cur        <= w_cur_nx;
            r_to_cnt     <= w_to_nx;
            r_gap_cnt    <= w_gap_nx;
            r_retry      <= w_retry_nx;
            r_retry_pend <= w_rpend_nx;
            r_done       <= w_done_nx;
            r_done_data  <= w_done_data_nx;
            r_err        <= w_err_nx;
            r_busy       <= (w_state_nx != S_IDLE);
        end
    end

endmodule

// File: doc/req_issuer.md
# req_issuer

Upstream requester for the req/ack edge-detect responder. The block queues command words, presents each one on a level `req` with `req_data`, holds `req` until the responder's one-cycle `ack` pulse, then drops `req` for a guaranteed low gap so the responder sees a fresh rising edge. Missing acks are handled with a timeout, a bounded retry count and an error pulse. It sits between the command source and the responder.

## Interface
- `DATA_W`, 8: width of command/request data.
- `DEPTH`, 4: command FIFO entries; power of 2, ≥2.
- `TIMEOUT`, 15: cycles `req` stays high without `ack` before the attempt is abandoned; ≥2.
- `MAX_RETRY`, 3: re-issues after a timeout; total attempts = MAX_RETRY+1.
- `GAP`, 2: cycles `req` is held low between attempts/transactions; ≥1.
- `clk`  in  1  clock; all logic on posedge.
- `rst`  in  1  reset; one clock; reset is asynchronous and active-high.
- `cmd_valid`  in  1  command offered.
- `cmd_data`  in  DATA_W  command word.
- `cmd_ready`  out  1  FIFO not full; accept = cmd_valid & cmd_ready at posedge.
- `req`  out  1  level request to responder; registered.
- `req_data`  out  DATA_W  data of current attempt; stable while req=1.
- `ack`  in  1  one-cycle acknowledge pulse from responder.
- `done`  out  1  one-cycle pulse: transaction acked.
- `done_data`  out  DATA_W  data of acked transaction; valid with done.
- `err`  out  1  one-cycle pulse: transaction dropped after last timeout.
- `busy`  out  1  FSM not IDLE.
- `pending`  out  $clog2(DEPTH+1)  FIFO occupancy.

## Operation
- FIFO: DEPTH entries, occupancy counter; `cmd_ready` = (pending != DEPTH), combinational from the count. Push when full is impossible; a pop and push at the same edge are both accepted when not full. A word pushed at edge E is poppable from edge E+1.
- States: IDLE, REQ, GAP.
- IDLE: if FIFO not empty, pop head into cur, clear retry and timeout counters, set req=1, req_data=cur → REQ.
- REQ: timeout counter increments each cycle.
  - ack=1: req=0, done=1, done_data=cur → GAP (no retry pending).
  - no ack, counter==TIMEOUT-1: req=0. If retry==MAX_RETRY, err=1 and cur is discarded → GAP with no retry pending. Otherwise retry++ → GAP with retry pending.
  - ack and timeout on the same edge: ack wins.
- GAP: gap counter runs GAP cycles. On its last edge:
  - retry pending: req=1 with same cur, timeout counter cleared → REQ.
  - else, FIFO not empty: pop, fresh transaction as in IDLE → REQ.
  - else → IDLE.
- `ack` outside REQ is ignored, with no state change.
- `done`/`err` are mutually exclusive, one pulse per transaction.
- Reset (async): FIFO emptied; FSM to IDLE; all counters cleared; req, req_data, done, done_data, err and busy = 0; pending = 0 and cmd_ready = 1. An in-flight transaction is lost without done/err.

## Timing
- Command accepted at edge E0 into an empty FIFO with FSM in IDLE: req rises after E0+1.
- ack sampled high at edge Ek: req low and done high in the cycle after Ek.
- Next req rises at Ek+GAP; req is low exactly GAP cycles between any two attempts.
- Timeout attempt: req high exactly TIMEOUT cycles, then low GAP cycles.
- All outputs except cmd_ready and pending are registered.
- Throughput with a responder acking on its 6th cycle: one transaction per 6+GAP cycles.

## Test plan
- Single cmd 0xA5, ack on req's 6th high cycle:
  - req rises 1 cycle after accept and stays high 6 cycles.
  - done=1 with done_data=0xA5 for one cycle; req low 2 cycles; then IDLE, busy=0.
- Four cmds 0x01–0x04 pushed back-to-back, ack after 6 cycles each:
  - pending reaches 3 (one popped immediately).
  - four done pulses in order, each 8 cycles apart; req low exactly 2 cycles between them.
- Fifth push while 4 pending: cmd_ready=0 and the word is not stored. Push a same-edge pop-and-push when pending=3: pending stays 3.
- ack never asserted for cmd 0x3C:
  - four attempts, each req high 15 cycles and low 2, all with req_data=0x3C.
  - err pulses once at the end of the 4th attempt; done never pulses.
- ack on the same cycle as the 15th high cycle: done=1, err=0, no retry.
- rst raised mid-REQ with 2 pending: req drops asynchronously, pending=0, no done/err. After release, a new cmd is issued normally.
